dds_phase_addr_gen: RTL and testbench
=====================================

// Module: dds_phase_addr_gen
// PURPOSE
//  Phase-accumulator (DDS) address generator for the AD9708 waveform ROM path.
//  Produces the 10-bit ROM address each clk_125M cycle from a programmable
//  frequency tuning word (FTW) and phase offset.
//  Supports phase-continuous retuning and an optional linear frequency sweep.
//  Sits upstream of the waveform ROM, replacing its fixed-step address counter.
// PARAMETERS
//  ACC_W    32            accumulator width; FTW width
//  ADDR_W   10            ROM address width = acc[ACC_W-1 -: ADDR_W]
//  FTW_RST  32'h0040_0000 FTW after reset (step 1 addr/cycle, ~122 kHz output)
// PORTS
//  clk_125M     in   1       DAC/ROM clock; all logic on posedge
//  rst          in   1       asynchronous, active-high reset
//  run          in   1       1 = generate, 0 = idle
//  cfg_valid    in   1       config word offered
//  cfg_ready    out  1       config slot free
//  cfg_ftw      in   ACC_W   new base FTW
//  cfg_poff     in   ADDR_W  new phase offset, in ROM-address units
//  sweep_en     in   1       1 = sweep FTW from base toward sweep_stop
//  sweep_step   in   ACC_W   FTW increment applied at each accumulator wrap
//  sweep_stop   in   ACC_W   sweep upper limit, inclusive
//  rom_addr     out  ADDR_W  registered ROM address
//  addr_valid   out  1       rom_addr is live (state RUN)
//  wrap_pulse   out  1       1-cycle pulse on accumulator carry-out
//  sweep_wrap   out  1       1-cycle pulse when sweep reloads base FTW
// BEHAVIOUR
//  Reset values
//   - acc=0; ftw_act=ftw_base=FTW_RST; poff_act=0; state=IDLE.
//   - rom_addr=0; addr_valid=0; wrap_pulse=0; sweep_wrap=0; cfg_ready=1.
//  FSM
//   - IDLE -> RUN when run=1. RUN -> IDLE when run=0.
//   - IDLE: acc=0; rom_addr=poff_act; addr_valid=0; no pulses.
//   - RUN, each cycle: {c,acc} <= acc + ftw_act.
//   - RUN, each cycle: rom_addr <= acc_next[ACC_W-1 -: ADDR_W] + poff_act, mod 2^ADDR_W.
//   - wrap_pulse <= c.
//  Latency
//   - First RUN cycle: rom_addr = top bits of ftw_act + poff_act, registered.
//   - ROM data follows rom_addr one cycle later.
//  Config handshake (one-deep shadow)
//   - Accept when cfg_valid & cfg_ready: latch {cfg_ftw, cfg_poff} to shadow; pending=1.
//   - cfg_ready = ~pending.
//   - IDLE: shadow moves to ftw_base/ftw_act/poff_act next cycle; pending clears.
//   - RUN: shadow applies on the first carry strictly after the accept cycle.
//     Applies in the same cycle as the wrap; acc is not cleared, so phase stays continuous.
//   - Carry in the accept cycle does not apply the shadow; it waits for the next wrap.
//   - run 1->0 while pending: pending resolves by the IDLE rule.
//  Sweep (RUN, sweep_en=1)
//   - At each carry with no pending apply: if ftw_act + sweep_step > sweep_stop,
//     ftw_act <= ftw_base and sweep_wrap=1; else ftw_act += sweep_step.
//   - The compare uses an ACC_W+1-bit sum, so overflow counts as exceeding stop.
//   - A pending config apply takes priority over the sweep step at that carry.
//   - sweep_en=0: ftw_act stays equal to ftw_base.
//  Boundaries
//   - FTW=0: acc frozen and no wrap_pulse; a pending config never applies until run=0.
//   - rom_addr wraps modulo 2^ADDR_W.
//   - rst mid-run: all state returns to reset values immediately; pending dropped.
// TESTING
//  1. rst=1, release, run=1, no cfg -> rom_addr 1,2,3,...
//     rom_addr 1023 -> 0 at cycle 1024; wrap_pulse on that cycle only.
//  2. IDLE: cfg ftw=32'h0080_0000, poff=1000; then run=1 -> rom_addr 1002,1004,...
//     rom_addr wraps 1022 -> 0 (mod 1024).
//  3. RUN at FTW_RST: accept ftw=32'h0100_0000 at addr 100 -> cfg_ready=0.
//     Step stays 1 until the wrap, then step=4 with no phase jump; cfg_ready=1 after.
//  4. Second cfg_valid while pending -> cfg_ready=0, word not taken.
//     cfg_valid held -> accepted the cycle after the apply.
//  5. sweep_en=1, base=FTW_RST, step=32'h0040_0000, stop=32'h0100_0000.
//     -> step 1,2,3,4 on successive wraps; then back to 1 with sweep_wrap=1.
//  6. run 1->0 mid-period -> next cycle addr_valid=0, acc=0, rom_addr=poff_act.
//     Assert rst mid-run -> outputs take reset values with no clock edge.

Source files
------------

// File: rtl/dds_phase_addr_gen.sv
// dds_phase_addr_gen
//   Phase-accumulator (DDS) address generator feeding the AD9708 waveform ROM.
//   It produces one ROM address per clk_125M cycle from a frequency tuning
//   word (FTW) and a phase offset. Retuning is phase-continuous, and an
//   optional linear FTW sweep is available.
//
// Ports
//   clk_125M    DAC/ROM clock, all logic on posedge
//   rst         asynchronous, active-high reset
//   run         1 = generate addresses, 0 = idle
//   cfg_valid   config word offered (cfg_ftw, cfg_poff)
//   cfg_ready   config shadow slot is free
//   cfg_ftw     new base FTW
//   cfg_poff    new phase offset, in ROM-address units
//   sweep_en    sweep FTW from base toward sweep_stop
//   sweep_step  FTW increment applied at each accumulator wrap
//   sweep_stop  inclusive sweep upper limit
//   rom_addr    registered ROM address
//   addr_valid  rom_addr is live (state RUN)
//   wrap_pulse  1-cycle pulse on accumulator carry-out
//   sweep_wrap  1-cycle pulse when the sweep reloads the base FTW
module dds_phase_addr_gen #(
  parameter int unsigned       ACC_W   = 32,
  parameter int unsigned       ADDR_W  = 10,
  parameter logic [ACC_W-1:0]  FTW_RST = 32'h0040_0000
) (
  input  logic              clk_125M,
  input  logic              rst,
  input  logic              run,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ACC_W-1:0]  cfg_ftw,
  input  logic [ADDR_W-1:0] cfg_poff,
  input  logic              sweep_en,
  input  logic [ACC_W-1:0]  sweep_step,
  input  logic [ACC_W-1:0]  sweep_stop,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              addr_valid,
  output logic              wrap_pulse,
  output logic              sweep_wrap
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    ftw_act;
  logic [ACC_W-1:0]    ftw_base;
  logic [ADDR_W-1:0]   poff_act;
  logic [ACC_W-1:0]    shadow_ftw;
  logic [ADDR_W-1:0]   shadow_poff;
  logic                pending;

  logic [ACC_W:0]      acc_sum;
  logic [ACC_W-1:0]    acc_next;
  logic                carry;
  logic [ACC_W:0]      sweep_sum;
  logic                sweep_over;
  logic                accept;
  logic [ADDR_W-1:0]   addr_next;

  always_comb begin
    acc_sum    = {1'b0, acc} + {1'b0, ftw_act};
    carry      = acc_sum[ACC_W];
    acc_next   = acc_sum[ACC_W-1:0];
    // Widened sum: an overflowing sweep step counts as exceeding the stop.
    sweep_sum  = {1'b0, ftw_act} + {1'b0, sweep_step};
    sweep_over = sweep_sum > {1'b0, sweep_stop};
    accept     = cfg_valid & ~pending;
    addr_next  = acc_next[ACC_W-1 -: ADDR_W] + poff_act;
  end

  assign cfg_ready  = ~pending;
  assign addr_valid = (state == RUN);

  // The run input, not the current state, selects the action, so that the
  // first generating edge and the first idle edge line up with run itself.
  always_ff @(posedge clk_125M or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      ftw_act     <= FTW_RST;
      ftw_base    <= FTW_RST;
      poff_act    <= '0;
      shadow_ftw  <= '0;
      shadow_poff <= '0;
      pending     <= 1'b0;
      rom_addr    <= '0;
      wrap_pulse  <= 1'b0;
      sweep_wrap  <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      sweep_wrap <= 1'b0;

      // accept needs ~pending and every apply needs pending: never both.
      if (accept) begin
        shadow_ftw  <= cfg_ftw;
        shadow_poff <= cfg_poff;
        pending     <= 1'b1;
      end

      if (run) begin
        state      <= RUN;
        acc        <= acc_next;
        rom_addr   <= addr_next;
        wrap_pulse <= carry;
        if (carry) begin
          // A pending config wins over the sweep step; acc is kept, so the
          // phase stays continuous across the retune.
          if (pending) begin
            ftw_base <= shadow_ftw;
            ftw_act  <= shadow_ftw;
            poff_act <= shadow_poff;
            pending  <= 1'b0;
          end else if (sweep_en) begin
            if (sweep_over) begin
              ftw_act    <= ftw_base;
              sweep_wrap <= 1'b1;
            end else begin
              ftw_act <= sweep_sum[ACC_W-1:0];
            end
          end else begin
            ftw_act <= ftw_base;
          end
        end
      end else begin
        state <= IDLE;
        acc   <= '0;
        // Forward the shadow offset so rom_addr tracks poff_act as it loads.
        if (pending) begin
          ftw_base <= shadow_ftw;
          ftw_act  <= shadow_ftw;
          poff_act <= shadow_poff;
          pending  <= 1'b0;
          rom_addr <= shadow_poff;
        end else begin
          rom_addr <= poff_act;
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_addr_gen.sv
// tb_dds_phase_addr_gen
//   Directed bench for dds_phase_addr_gen: table of per-cycle vectors plus
//   hand-written sequences for wrap, retune, sweep and reset behaviour.
module tb_dds_phase_addr_gen;

  logic        clk_125M = 1'b0;
  logic        rst;
  logic        run;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_ftw;
  logic [9:0]  cfg_poff;
  logic        sweep_en;
  logic [31:0] sweep_step;
  logic [31:0] sweep_stop;
  logic [9:0]  rom_addr;
  logic        addr_valid;
  logic        wrap_pulse;
  logic        sweep_wrap;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        run;
    logic        cv;
    logic [31:0] ftw;
    logic [9:0]  poff;
    logic [9:0]  e_addr;
    logic        e_valid;
    logic        e_ready;
    logic        e_wrap;
  } vec_t;

  vec_t vq[$];

  dds_phase_addr_gen #(
    .ACC_W   (32),
    .ADDR_W  (10),
    .FTW_RST (32'h0040_0000)
  ) dut (
    .clk_125M   (clk_125M),
    .rst        (rst),
    .run        (run),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ftw    (cfg_ftw),
    .cfg_poff   (cfg_poff),
    .sweep_en   (sweep_en),
    .sweep_step (sweep_step),
    .sweep_stop (sweep_stop),
    .rom_addr   (rom_addr),
    .addr_valid (addr_valid),
    .wrap_pulse (wrap_pulse),
    .sweep_wrap (sweep_wrap)
  );

  always #4 clk_125M = ~clk_125M;

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rom_addr"},   32'(rom_addr),   32'd0);
    chk({tag, " addr_valid"}, 32'(addr_valid), 32'd0);
    chk({tag, " wrap_pulse"}, 32'(wrap_pulse), 32'd0);
    chk({tag, " sweep_wrap"}, 32'(sweep_wrap), 32'd0);
    chk({tag, " cfg_ready"},  32'(cfg_ready),  32'd1);
  endtask

  // Called just after a negedge: asserts rst between clock edges, checks the
  // asynchronous response, then releases rst on a later negedge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 chk_reset_outputs(tag);
    run       = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk_125M);
    rst = 1'b0;
  endtask

  initial begin
    int m_addr;
    int m_s;
    int a;
    logic e_wrap;
    logic e_sw;
    int sw_seen;

    rst        = 1'b1;
    run        = 1'b0;
    cfg_valid  = 1'b0;
    cfg_ftw    = '0;
    cfg_poff   = '0;
    sweep_en   = 1'b0;
    sweep_step = '0;
    sweep_stop = '0;

    // ---- reset values ----
    #1 chk_reset_outputs("reset");
    @(negedge clk_125M);
    @(negedge clk_125M);
    rst = 1'b0;

    // ---- default FTW: step 1, wrap after 1024 cycles ----
    run = 1'b1;
    for (int k = 1; k <= 1025; k++) begin
      @(negedge clk_125M);
      chk("t1 rom_addr", 32'(rom_addr), 32'(k % 1024));
      chk("t1 wrap_pulse", 32'(wrap_pulse), (k == 1024) ? 32'd1 : 32'd0);
      chk("t1 addr_valid", 32'(addr_valid), 32'd1);
    end

    // ---- table: idle config, poff wrap, run toggling, FTW=0 ----
    vq.push_back('{1'b0, 1'b0, 32'h0,         10'd0,    10'd0,    1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 32'h0080_0000, 10'd1000, 10'd0,    1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 32'h0,         10'd0,    10'd1000, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 32'h0,         10'd0,    10'd1000, 1'b0, 1'b1, 1'b0});
    for (int n = 1; n <= 14; n++)
      vq.push_back('{1'b1, 1'b0, 32'h0, 10'd0, 10'((1000 + 2 * n) % 1024), 1'b1, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 32'h0,         10'd0,    10'd1000, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h0,         10'd0,    10'd1002, 1'b1, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 32'h0,         10'd3,    10'd1000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 32'h0,         10'd0,    10'd3,    1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h0,         10'd0,    10'd3,    1'b1, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 32'h0040_0000, 10'd0,    10'd3,    1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h0,         10'd0,    10'd3,    1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h0,         10'd0,    10'd3,    1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 32'h0,         10'd0,    10'd0,    1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h0,         10'd0,    10'd1,    1'b1, 1'b1, 1'b0});

    foreach (vq[i]) begin
      run       = vq[i].run;
      cfg_valid = vq[i].cv;
      cfg_ftw   = vq[i].ftw;
      cfg_poff  = vq[i].poff;
      @(negedge clk_125M);
      chk($sformatf("vec%0d rom_addr", i),   32'(rom_addr),   32'(vq[i].e_addr));
      chk($sformatf("vec%0d addr_valid", i), 32'(addr_valid), 32'(vq[i].e_valid));
      chk($sformatf("vec%0d cfg_ready", i),  32'(cfg_ready),  32'(vq[i].e_ready));
      chk($sformatf("vec%0d wrap_pulse", i), 32'(wrap_pulse), 32'(vq[i].e_wrap));
    end
    cfg_valid = 1'b0;

    // ---- asynchronous reset while running ----
    async_reset("rst_run");

    // ---- retune at wrap, second offer while pending ----
    run = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      @(negedge clk_125M);
      chk("t3 lead rom_addr", 32'(rom_addr), 32'(e));
    end
    cfg_valid = 1'b1;
    cfg_ftw   = 32'h0100_0000;
    cfg_poff  = 10'd0;
    @(negedge clk_125M);
    chk("t3 accept rom_addr", 32'(rom_addr), 32'd101);
    chk("t3 accept cfg_ready", 32'(cfg_ready), 32'd0);
    cfg_ftw  = 32'h0080_0000;
    cfg_poff = 10'd5;
    for (int e = 102; e <= 1023; e++) begin
      @(negedge clk_125M);
      chk("t3 pend rom_addr", 32'(rom_addr), 32'(e));
      chk("t4 pend cfg_ready", 32'(cfg_ready), 32'd0);
    end
    @(negedge clk_125M);
    chk("t3 apply rom_addr", 32'(rom_addr), 32'd0);
    chk("t3 apply wrap_pulse", 32'(wrap_pulse), 32'd1);
    chk("t3 apply cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk_125M);
    chk("t3 step4 rom_addr", 32'(rom_addr), 32'd4);
    chk("t4 reaccept cfg_ready", 32'(cfg_ready), 32'd0);
    chk("t3 step4 wrap_pulse", 32'(wrap_pulse), 32'd0);
    cfg_valid = 1'b0;
    for (int e = 8; e <= 1020; e += 4) begin
      @(negedge clk_125M);
      chk("t3 step4 seq rom_addr", 32'(rom_addr), 32'(e));
    end
    @(negedge clk_125M);
    chk("t4 apply rom_addr", 32'(rom_addr), 32'd0);
    chk("t4 apply wrap_pulse", 32'(wrap_pulse), 32'd1);
    chk("t4 apply cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk_125M);
    chk("t4 poff rom_addr a", 32'(rom_addr), 32'd7);
    @(negedge clk_125M);
    chk("t4 poff rom_addr b", 32'(rom_addr), 32'd9);

    async_reset("rst_t4");

    // ---- linear sweep: steps 1,2,3,4 then reload ----
    sweep_en   = 1'b1;
    sweep_step = 32'h0040_0000;
    sweep_stop = 32'h0100_0000;
    run        = 1'b1;
    m_addr  = 0;
    m_s     = 1;
    sw_seen = 0;
    for (int c = 0; c < 2240; c++) begin
      @(negedge clk_125M);
      a      = m_addr + m_s;
      e_wrap = (a >= 1024);
      m_addr = a % 1024;
      e_sw   = 1'b0;
      if (e_wrap) begin
        if (m_s + 1 > 4) begin
          m_s  = 1;
          e_sw = 1'b1;
        end else begin
          m_s++;
        end
      end
      if (sweep_wrap) sw_seen++;
      chk("t5 rom_addr", 32'(rom_addr), 32'(m_addr));
      chk("t5 wrap_pulse", 32'(wrap_pulse), 32'(e_wrap));
      chk("t5 sweep_wrap", 32'(sweep_wrap), 32'(e_sw));
    end
    chk("t5 sweep_wrap count", 32'(sw_seen), 32'd1);

    // ---- reset drops a pending config ----
    cfg_valid = 1'b1;
    cfg_ftw   = 32'h0123_4567;
    cfg_poff  = 10'd77;
    @(negedge clk_125M);
    cfg_valid = 1'b0;
    chk("t6 pend cfg_ready", 32'(cfg_ready), 32'd0);
    async_reset("rst_pend");
    @(negedge clk_125M);
    chk("t6 idle rom_addr", 32'(rom_addr), 32'd0);
    chk("t6 idle cfg_ready", 32'(cfg_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
